ssd_scan_driver: RTL and testbench

Display scan stage that drives the dual-digit seven-segment Pmod from the 32-bit display word written over AXI-lite. It accepts a new display word through a valid/ready handshake and holds it in a one-deep pending slot. The word goes live only at a frame boundary, so the display never tears mid-frame. The block then time-multiplexes the two digits with a prescaled digit-select, and applies hex decode, per-digit blanking, PWM brightness, blink and anti-ghosting dead time. Its registered `seg`/`dsel` outputs are mapped onto the Pmod pins by the enclosing core.

---
 rtl/ssd_scan_driver.sv | 200 ++++++++++++++++++++
 tb/tb_ssd_scan_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//
// Display scan stage for a dual-digit seven-segment Pmod. A 32-bit display
// word arrives over a valid/ready handshake into a one-deep pending slot. The
// word is promoted to the active register only at a frame boundary, so a
// frame never shows a mix of old and new settings. The two digits are
// time-multiplexed with a prescaled digit select. Each slot applies hex
// decode, per-digit blanking, anti-ghosting dead time, 4-bit PWM brightness
// and a frame-based blink.
//
// Parameters
//   PRESCALE_DIV : clk cycles per digit slot (>= DEAD_CYCLES+2); frame = 2 slots
//   DEAD_CYCLES  : cycles at the start of each slot with all segments off
//   BLINK_FRAMES : frames per blink half-period (>= 1)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   cfg_valid  in   display word valid
//   cfg_ready  out  pending slot can accept a word
//   cfg_data   in   [3:0] digit0, [7:4] digit1, [8] blank0, [9] blank1,
//                   [10] blink_en, [15:12] brightness, other bits ignored
//   seg        out  {g,f,e,d,c,b,a}, active-high, registered
//   dsel       out  0 = digit0 lit, 1 = digit1 lit, registered
//   frame_tick out  one-cycle pulse in the first cycle of each frame
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
  parameter int PRESCALE_DIV = 100000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_data,
  output logic [6:0]  seg,
  output logic        dsel,
  output logic        frame_tick
);

  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PCNT_LAST  = PW'(PRESCALE_DIV - 1);
  localparam logic [PW-1:0] DEAD_LIMIT = PW'(DEAD_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Display settings extracted from the configuration word.
  typedef struct packed {
    logic [3:0] bright;
    logic       blink_en;
    logic       blank1;
    logic       blank0;
    logic [3:0] dig1;
    logic [3:0] dig0;
  } disp_t;

  // Reset state keeps both digits blanked so the display starts dark.
  localparam disp_t DISP_RESET = '{
    bright:   4'd0,
    blink_en: 1'b0,
    blank1:   1'b1,
    blank0:   1'b1,
    dig1:     4'd0,
    dig0:     4'd0
  };

  function automatic disp_t unpack_word(input logic [31:0] w);
    disp_t d;
    d.bright   = w[15:12];
    d.blink_en = w[10];
    d.blank1   = w[9];
    d.blank0   = w[8];
    d.dig1     = w[7:4];
    d.dig0     = w[3:0];
    return d;
  endfunction

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    s = 7'h00;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Bits of the configuration word that carry no display setting.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{cfg_data[31:16], cfg_data[11]};

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;
  logic          dsel_nxt;
  logic          pcnt_last;
  logic          apply;
  logic          accept;
  logic [3:0]    pwm_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          pend_full;
  disp_t         pend_word;
  disp_t         active;
  logic [3:0]    sel_digit;
  logic          sel_blank;
  logic [6:0]    seg_nxt;

  assign pcnt_last = (pcnt == PCNT_LAST);
  assign pcnt_nxt  = pcnt_last ? '0 : pcnt + 1'b1;
  assign dsel_nxt  = dsel ^ pcnt_last;

  // The frame boundary is the dsel 1->0 toggle; the pending word is promoted
  // on that same edge.
  assign apply = pcnt_last && dsel;

  // The slot may take a new word on the same edge the old one is promoted.
  assign cfg_ready = !rst && (!pend_full || apply);
  assign accept    = cfg_valid && cfg_ready;

  // Segment data is computed against the slot the registers are about to
  // enter, so seg and dsel change on the same edge and a digit's pattern
  // never leaks into its neighbour's slot. Brightness, blink and the active
  // word are taken from their current values (one cycle of latency).
  assign sel_digit = dsel_nxt ? active.dig1   : active.dig0;
  assign sel_blank = dsel_nxt ? active.blank1 : active.blank0;

  always_comb begin
    seg_nxt = 7'h00;
    if (!sel_blank &&
        (pcnt_nxt >= DEAD_LIMIT) &&
        (pwm_cnt <= active.bright) &&
        !(active.blink_en && blink_phase)) begin
      seg_nxt = hex_decode(sel_digit);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt        <= '0;
      dsel        <= 1'b0;
      frame_tick  <= 1'b0;
      pwm_cnt     <= 4'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pend_full   <= 1'b0;
      pend_word   <= DISP_RESET;
      active      <= DISP_RESET;
      seg         <= 7'h00;
    end else begin
      pcnt       <= pcnt_nxt;
      dsel       <= dsel_nxt;
      frame_tick <= apply;
      pwm_cnt    <= pwm_cnt + 4'd1;
      seg        <= seg_nxt;

      if (apply) begin
        if (pend_full) begin
          active <= pend_word;
        end
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= !blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      // Acceptance wins over the clear when both happen on one edge.
      if (accept) begin
        pend_word <= unpack_word(cfg_data);
        pend_full <= 1'b1;
      end else if (apply) begin
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
//
// Self-checking bench for ssd_scan_driver with small parameters. A reference
// model derives every expected output from the cycle count since reset
// (slot, frame and blink phase by plain division) and from a transaction-
// level pending/active word pair. Directed scenarios are followed by a
// randomized section.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

  localparam int P = 8;
  localparam int D = 2;
  localparam int B = 2;
  localparam int FRAME = 2 * P;
  localparam logic [31:0] RESET_WORD = 32'h0000_0300;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic [6:0]  seg;
  logic        dsel;
  logic        frame_tick;

  always #5 clk = ~clk;

  ssd_scan_driver #(
    .PRESCALE_DIV(P),
    .DEAD_CYCLES (D),
    .BLINK_FRAMES(B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .seg       (seg),
    .dsel      (dsel),
    .frame_tick(frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n counts non-reset edges since the last reset edge.
  int          m_n;
  bit          m_full;
  logic [31:0] m_pend;
  logic [31:0] m_act;
  logic [6:0]  m_seg;
  bit          m_acc;

  logic [6:0] seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                 7'h39, 7'h5E, 7'h79, 7'h71};

  // Pattern the display shows in state n+1, given state n's settings.
  function automatic logic [6:0] model_seg(input int n, input logic [31:0] act);
    int   nn    = n + 1;
    int   slot  = nn % P;
    int   digit = (nn / P) % 2;
    int   pwm   = n % 16;
    int   phase = ((n / FRAME) / B) % 2;
    int   hex   = (digit == 1) ? int'(act[7:4]) : int'(act[3:0]);
    bit   blank = (digit == 1) ? act[9] : act[8];
    if (blank) return 7'h00;
    if (slot < D) return 7'h00;
    if (pwm > int'(act[15:12])) return 7'h00;
    if (act[10] && phase == 1) return 7'h00;
    return seg_table[hex];
  endfunction

  // One clock: advance the model on the rising edge, compare on the falling.
  task automatic step();
    bit boundary;
    bit ready_b;
    @(posedge clk);
    if (rst) begin
      m_n    = 0;
      m_full = 0;
      m_act  = RESET_WORD;
      m_seg  = 7'h00;
      m_acc  = 0;
    end else begin
      boundary = ((m_n + 1) % FRAME == 0);
      ready_b  = !m_full || boundary;
      m_seg    = model_seg(m_n, m_act);
      m_acc    = cfg_valid && ready_b;
      if (boundary) begin
        if (m_full) m_act = m_pend;
        m_full = 0;
      end
      if (m_acc) begin
        m_pend = cfg_data;
        m_full = 1;
      end
      m_n++;
    end
    @(negedge clk);
    check("seg", 32'(seg), 32'(m_seg));
    check("dsel", 32'(dsel), 32'((m_n / P) % 2));
    check("frame_tick", 32'(frame_tick), 32'(m_n > 0 && m_n % FRAME == 0));
    check("cfg_ready", 32'(cfg_ready),
          32'(!rst && (!m_full || ((m_n + 1) % FRAME == 0))));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Offer one word and hold it until the model reports the transfer.
  task automatic send(input logic [31:0] word);
    int waited = 0;
    cfg_valid = 1'b1;
    cfg_data  = word;
    do begin
      step();
      waited++;
    end while (!m_acc && waited < 4 * FRAME);
    if (!m_acc) check("send_timeout", 32'(waited), 32'(0));
    cfg_valid = 1'b0;
  endtask

  int ft_count;
  int ft_first;
  int lit_count;

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    m_n = 0; m_full = 0; m_pend = '0; m_act = RESET_WORD; m_seg = '0; m_acc = 0;
    run(3);

    // Idle after reset: dark display, 8-cycle slots, ticks at 16 and 32.
    rst      = 1'b0;
    ft_count = 0;
    ft_first = -1;
    lit_count = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (frame_tick) begin
        ft_count++;
        if (ft_first < 0) ft_first = i;
      end
      if (seg != 7'h00) lit_count++;
    end
    check("idle_ticks", 32'(ft_count), 32'd2);
    check("idle_first_tick", 32'(ft_first), 32'd16);
    check("idle_dark", 32'(lit_count), 32'd0);

    // Single word: digit0=1 (06), digit1=2 (5B).
    send(32'h0000_F021);
    run(3 * FRAME);

    // Back-to-back words: the second waits in the pending slot.
    send(32'h0000_F021);
    send(32'h0000_F0E3);
    run(3 * FRAME);

    // Brightness 3: 4 of every 16 cycles lit.
    send(32'h0000_3088);
    run(4 * FRAME);

    // Blink, then blank digit1.
    send(32'h0000_F455);
    run(10 * FRAME);
    send(32'h0000_F255);
    run(3 * FRAME);

    // Reset mid-frame with a word sitting in the pending slot.
    begin
      int guard = 0;
      while (m_n % FRAME != 1 && guard < 2 * FRAME) begin
        step();
        guard++;
      end
    end
    send(32'h0000_F0AA);
    run(3);
    check("pending_before_rst", 32'(m_full), 32'd1);
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 32'h0000_F077;
    run(2);
    cfg_valid = 1'b0;
    rst       = 1'b0;
    lit_count = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      if (seg != 7'h00) lit_count++;
    end
    check("post_rst_dark", 32'(lit_count), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_data  = $urandom();
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst       = 1'b0;
    cfg_valid = 1'b0;
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
